// File: rtl/tcam_entry_loader.sv
// Write-side TCAM controller: takes one entry-update request at a time, pulses the
// TCAM write port, waits out BUSY, optionally reads the entry back and reports status.
module tcam_entry_loader #(
    parameter int unsigned C_TCAM_ADDR_WIDTH = 5,
    parameter int unsigned C_TCAM_DATA_WIDTH = 32,
    parameter int unsigned C_BUSY_GUARD      = 2,
    parameter int unsigned C_CMP_LAT         = 2,
    parameter int unsigned C_TIMEOUT         = 1024
) (
    input  logic                         CLK,
    input  logic                         RESETN,
    input  logic                         REQ_VALID,
    output logic                         REQ_READY,
    input  logic [C_TCAM_ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [C_TCAM_DATA_WIDTH-1:0] REQ_DATA,
    input  logic [C_TCAM_DATA_WIDTH-1:0] REQ_MASK,
    input  logic                         REQ_VERIFY,
    output logic                         WE,
    output logic [C_TCAM_ADDR_WIDTH-1:0] ADDR_WR,
    output logic [C_TCAM_DATA_WIDTH-1:0] DIN,
    output logic [C_TCAM_DATA_WIDTH-1:0] DATA_MASK,
    input  logic                         BUSY,
    output logic                         CMP_SEL,
    output logic [C_TCAM_DATA_WIDTH-1:0] CMP_DIN,
    output logic [C_TCAM_DATA_WIDTH-1:0] CMP_DATA_MASK,
    input  logic                         MATCH,
    input  logic [C_TCAM_ADDR_WIDTH-1:0] MATCH_ADDR,
    output logic                         STS_VALID,
    output logic [1:0]                   STS_ERR,
    output logic [C_TCAM_ADDR_WIDTH-1:0] STS_ADDR,
    output logic [31:0]                  WR_CNT
);

    localparam int unsigned CntW = $clog2(C_TIMEOUT + 1);
    localparam logic [CntW-1:0] GuardCnt   = CntW'(C_BUSY_GUARD);
    localparam logic [CntW-1:0] TimeoutEnd = CntW'(C_TIMEOUT - 1);
    localparam logic [CntW-1:0] CmpEnd     = CntW'(C_CMP_LAT);

    localparam logic [1:0] ErrOk       = 2'b00;
    localparam logic [1:0] ErrNoMatch  = 2'b01;
    localparam logic [1:0] ErrShadowed = 2'b10;
    localparam logic [1:0] ErrTimeout  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWait,
        StVerify,
        StReport
    } state_e;

    state_e                       state_q, state_d;
    logic [C_TCAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_TCAM_DATA_WIDTH-1:0] data_q, data_d;
    logic [C_TCAM_DATA_WIDTH-1:0] mask_q, mask_d;
    logic                         verify_q, verify_d;
    logic [CntW-1:0]              cnt_q, cnt_d;
    logic [31:0]                  wr_cnt_q, wr_cnt_d;
    logic [1:0]                   err_q, err_d;
    logic [C_TCAM_ADDR_WIDTH-1:0] sts_addr_q, sts_addr_d;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            verify_q   <= 1'b0;
            cnt_q      <= '0;
            wr_cnt_q   <= '0;
            err_q      <= '0;
            sts_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            mask_q     <= mask_d;
            verify_q   <= verify_d;
            cnt_q      <= cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            err_q      <= err_d;
            sts_addr_q <= sts_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        mask_d     = mask_q;
        verify_d   = verify_q;
        cnt_d      = cnt_q;
        wr_cnt_d   = wr_cnt_q;
        err_d      = err_q;
        sts_addr_d = sts_addr_q;
        REQ_READY  = 1'b0;
        WE         = 1'b0;
        CMP_SEL    = 1'b0;
        STS_VALID  = 1'b0;

        case (state_q)
            StIdle: begin
                REQ_READY = !BUSY;
                if (REQ_VALID && !BUSY) begin
                    addr_d   = REQ_ADDR;
                    data_d   = REQ_DATA;
                    mask_d   = REQ_MASK;
                    verify_d = REQ_VERIFY;
                    state_d  = StWrite;
                end
            end
            StWrite: begin
                WE       = 1'b1;
                wr_cnt_d = wr_cnt_q + 32'd1;
                cnt_d    = '0;
                state_d  = StWait;
            end
            StWait: begin
                // BUSY may lag WE, so it is only trusted once the guard has elapsed.
                if (cnt_q >= GuardCnt && !BUSY) begin
                    cnt_d = '0;
                    if (verify_q) begin
                        state_d = StVerify;
                    end else begin
                        err_d      = ErrOk;
                        sts_addr_d = addr_q;
                        state_d    = StReport;
                    end
                end else if (cnt_q == TimeoutEnd) begin
                    err_d      = ErrTimeout;
                    sts_addr_d = addr_q;
                    state_d    = StReport;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StVerify: begin
                CMP_SEL = 1'b1;
                if (cnt_q == CmpEnd) begin
                    if (!MATCH) begin
                        err_d = ErrNoMatch;
                    end else if (MATCH_ADDR != addr_q) begin
                        err_d = ErrShadowed;
                    end else begin
                        err_d = ErrOk;
                    end
                    sts_addr_d = addr_q;
                    state_d    = StReport;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StReport: begin
                STS_VALID = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign ADDR_WR       = addr_q;
    assign DIN           = data_q;
    assign DATA_MASK     = mask_q;
    assign CMP_DIN       = data_q;
    assign CMP_DATA_MASK = mask_q;
    assign STS_ERR       = err_q;
    assign STS_ADDR      = sts_addr_q;
    assign WR_CNT        = wr_cnt_q;

endmodule

// File: tb/tb_tcam_entry_loader.sv
// Bench for tcam_entry_loader: behavioural TCAM (BUSY timer, entry array, 2-cycle compare)
// plus a status scoreboard fed at request time and drained on STS_VALID.
module tb_tcam_entry_loader;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [4:0]  REQ_ADDR = '0;
    logic [31:0] REQ_DATA = '0;
    logic [31:0] REQ_MASK = '0;
    logic        REQ_VERIFY = 1'b0;
    logic        WE;
    logic [4:0]  ADDR_WR;
    logic [31:0] DIN;
    logic [31:0] DATA_MASK;
    logic        BUSY;
    logic        CMP_SEL;
    logic [31:0] CMP_DIN;
    logic [31:0] CMP_DATA_MASK;
    logic        MATCH;
    logic [4:0]  MATCH_ADDR;
    logic        STS_VALID;
    logic [1:0]  STS_ERR;
    logic [4:0]  STS_ADDR;
    logic [31:0] WR_CNT;

    tcam_entry_loader dut (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .REQ_VALID    (REQ_VALID),
        .REQ_READY    (REQ_READY),
        .REQ_ADDR     (REQ_ADDR),
        .REQ_DATA     (REQ_DATA),
        .REQ_MASK     (REQ_MASK),
        .REQ_VERIFY   (REQ_VERIFY),
        .WE           (WE),
        .ADDR_WR      (ADDR_WR),
        .DIN          (DIN),
        .DATA_MASK    (DATA_MASK),
        .BUSY         (BUSY),
        .CMP_SEL      (CMP_SEL),
        .CMP_DIN      (CMP_DIN),
        .CMP_DATA_MASK(CMP_DATA_MASK),
        .MATCH        (MATCH),
        .MATCH_ADDR   (MATCH_ADDR),
        .STS_VALID    (STS_VALID),
        .STS_ERR      (STS_ERR),
        .STS_ADDR     (STS_ADDR),
        .WR_CNT       (WR_CNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // TCAM model
    int          busy_len = 4;
    int          busy_cnt = 0;
    logic        busy_force = 1'b0;
    logic        force_nomatch = 1'b0;
    logic [31:0] ent_d [32];
    logic [31:0] ent_m [32];
    logic [31:0] ent_v = '0;
    logic        m1 = 1'b0, m2 = 1'b0;
    logic [4:0]  ma1 = '0, ma2 = '0;

    assign BUSY       = busy_force || (busy_cnt != 0);
    assign MATCH      = m2 && !force_nomatch;
    assign MATCH_ADDR = ma2;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (WE) begin
            ent_d[ADDR_WR] <= DIN;
            ent_m[ADDR_WR] <= DATA_MASK;
            ent_v[ADDR_WR] <= 1'b1;
            busy_cnt       <= busy_len;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        m1  <= 1'b0;
        ma1 <= '0;
        if (CMP_SEL) begin
            // Descending scan so the lowest matching index wins.
            for (int i = 31; i >= 0; i--) begin
                if (ent_v[i] && (((ent_d[i] ^ CMP_DIN) & ~(ent_m[i] | CMP_DATA_MASK)) == 32'd0)) begin
                    m1  <= 1'b1;
                    ma1 <= i[4:0];
                end
            end
        end
        m2  <= m1;
        ma2 <= ma1;
    end

    // Scoreboard and protocol monitor
    typedef struct packed {
        logic [1:0] err;
        logic [4:0] addr;
    } sts_t;

    sts_t exp_q[$];
    int   we_count = 0;
    int   we_cyc = 0;
    int   sts_count = 0;
    int   sts_cyc = 0;
    logic cmp_seen = 1'b0;

    always @(negedge CLK) begin
        sts_t e;
        if (WE) begin
            we_count++;
            we_cyc = cyc;
            checks++;
            if (BUSY !== 1'b0) begin
                errors++;
                $display("FAIL we_while_busy: BUSY=%b at WE, required 0", BUSY);
            end
        end
        if (CMP_SEL) cmp_seen = 1'b1;
        if (STS_VALID) begin
            sts_count++;
            sts_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sts_unexpected: got err=%b addr=%0d, none expected",
                         STS_ERR, STS_ADDR);
            end else begin
                e = exp_q.pop_front();
                if ({STS_ERR, STS_ADDR} !== e) begin
                    errors++;
                    $display("FAIL sts_order: got err=%b addr=%0d, required err=%b addr=%0d",
                             STS_ERR, STS_ADDR, e.err, e.addr);
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge CLK);
        RESETN = 1'b0;
        REQ_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        exp_q.delete();
        RESETN = 1'b1;
        @(negedge CLK);
    endtask

    task automatic send_req(input logic [4:0] addr, input logic [31:0] data,
                            input logic [31:0] mask, input logic verify,
                            input logic [1:0] exp_err, input logic keep);
        int n = 0;
        exp_q.push_back({exp_err, addr});
        REQ_VALID  = 1'b1;
        REQ_ADDR   = addr;
        REQ_DATA   = data;
        REQ_MASK   = mask;
        REQ_VERIFY = verify;
        while (REQ_READY !== 1'b1 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL req_accept: REQ_READY=%b after %0d cycles, required 1", REQ_READY, n);
        end
        @(posedge CLK);
        #1;
        if (!keep) REQ_VALID = 1'b0;
    endtask

    task automatic wait_sts(input int target, input int budget);
        int n = 0;
        while (sts_count < target && n < budget) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        checks++;
        if (sts_count < target) begin
            errors++;
            $display("FAIL sts_timeout: sts_count=%0d, required %0d", sts_count, target);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({WE, CMP_SEL, STS_VALID, STS_ERR, STS_ADDR, ADDR_WR, DIN, DATA_MASK,
             CMP_DIN, CMP_DATA_MASK, WR_CNT} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: WE=%b CMP_SEL=%b STS_VALID=%b WR_CNT=%0h DIN=%h, required 0",
                     WE, CMP_SEL, STS_VALID, WR_CNT, DIN);
        end
        checks++;
        if (REQ_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: REQ_READY=%b, required 1", REQ_READY);
        end
    endtask

    task automatic test_verify_ok();
        int s0 = sts_count;
        busy_len = 16;
        cmp_seen = 1'b0;
        send_req(5'd5, 32'hDEAD_BEEF, 32'h0, 1'b1, 2'b00, 1'b0);
        wait_sts(s0 + 1, 200);
        repeat (2) @(negedge CLK);
        checks++;
        if (we_count !== 1 || WR_CNT !== 32'd1) begin
            errors++;
            $display("FAIL verify_ok_wr: we_count=%0d WR_CNT=%0d, required 1 and 1", we_count, WR_CNT);
        end
        checks++;
        if (STS_ERR !== 2'b00 || STS_ADDR !== 5'd5 || cmp_seen !== 1'b1) begin
            errors++;
            $display("FAIL verify_ok_hold: err=%b addr=%0d cmp_seen=%b, required 00 5 1",
                     STS_ERR, STS_ADDR, cmp_seen);
        end
    endtask

    task automatic test_shadowed();
        int s0 = sts_count;
        busy_len = 3;
        send_req(5'd2, 32'hCAFE_F00D, 32'h0, 1'b0, 2'b00, 1'b0);
        wait_sts(s0 + 1, 200);
        send_req(5'd9, 32'hCAFE_F00D, 32'h0, 1'b1, 2'b10, 1'b0);
        wait_sts(s0 + 2, 200);
        checks++;
        if (STS_ERR !== 2'b10 || STS_ADDR !== 5'd9) begin
            errors++;
            $display("FAIL shadowed: err=%b addr=%0d, required 10 9", STS_ERR, STS_ADDR);
        end
    endtask

    task automatic test_no_match();
        int s0 = sts_count;
        busy_len = 1;
        force_nomatch = 1'b1;
        send_req(5'd12, 32'h1234_5678, 32'h0, 1'b1, 2'b01, 1'b0);
        wait_sts(s0 + 1, 200);
        force_nomatch = 1'b0;
        checks++;
        if (sts_cyc - we_cyc !== 7) begin
            errors++;
            $display("FAIL verify_latency: WE->STS=%0d cycles, required 7", sts_cyc - we_cyc);
        end
        cmp_seen = 1'b0;
        send_req(5'd12, 32'h1234_5678, 32'h0, 1'b0, 2'b00, 1'b0);
        wait_sts(s0 + 2, 200);
        checks++;
        if (cmp_seen !== 1'b0) begin
            errors++;
            $display("FAIL noverify_cmp_sel: cmp_seen=%b, required 0", cmp_seen);
        end
        checks++;
        if (sts_cyc - we_cyc !== 4) begin
            errors++;
            $display("FAIL noverify_latency: WE->STS=%0d cycles, required 4", sts_cyc - we_cyc);
        end
    endtask

    task automatic test_timeout();
        int s0 = sts_count;
        int n = 0;
        busy_len = 1500;
        cmp_seen = 1'b0;
        send_req(5'd3, 32'h0BAD_F00D, 32'h0, 1'b1, 2'b11, 1'b0);
        wait_sts(s0 + 1, 1200);
        checks++;
        if (sts_cyc - we_cyc !== 1025) begin
            errors++;
            $display("FAIL timeout_latency: WE->STS=%0d cycles, required 1025", sts_cyc - we_cyc);
        end
        checks++;
        if (cmp_seen !== 1'b0 || STS_ERR !== 2'b11) begin
            errors++;
            $display("FAIL timeout_status: cmp_seen=%b err=%b, required 0 11", cmp_seen, STS_ERR);
        end
        checks++;
        if (REQ_READY !== 1'b0) begin
            errors++;
            $display("FAIL timeout_ready: REQ_READY=%b while BUSY, required 0", REQ_READY);
        end
        while (BUSY && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (REQ_READY !== 1'b1) begin
            errors++;
            $display("FAIL timeout_release: REQ_READY=%b after BUSY fell, required 1", REQ_READY);
        end
    endtask

    task automatic test_back_to_back();
        int s0;
        int w0;
        apply_reset();
        s0 = sts_count;
        w0 = we_count;
        busy_len = 6;
        for (int i = 0; i < 4; i++) begin
            send_req(5'(20 + i), 32'h1111_0000 + i, 32'h0, 1'b1, 2'b00, (i != 3));
        end
        wait_sts(s0 + 4, 400);
        checks++;
        if (we_count - w0 !== 4 || WR_CNT !== 32'd4) begin
            errors++;
            $display("FAIL b2b_count: WE pulses=%0d WR_CNT=%0d, required 4 4", we_count - w0, WR_CNT);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL b2b_pending: %0d statuses missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_verify();
        int s0;
        int n = 0;
        busy_len = 2;
        s0 = sts_count;
        send_req(5'd7, 32'h7777_7777, 32'h0, 1'b1, 2'b00, 1'b0);
        while (CMP_SEL !== 1'b1 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        busy_force = 1'b1;
        RESETN = 1'b0;
        @(negedge CLK);
        exp_q.delete();
        checks++;
        if ({WE, CMP_SEL, STS_VALID, STS_ERR, STS_ADDR, ADDR_WR, DIN, DATA_MASK,
             CMP_DIN, CMP_DATA_MASK, WR_CNT, REQ_READY} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: CMP_SEL=%b WR_CNT=%0d DIN=%h REQ_READY=%b, required 0",
                     CMP_SEL, WR_CNT, DIN, REQ_READY);
        end
        RESETN = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (REQ_READY !== 1'b0 || sts_count !== s0) begin
            errors++;
            $display("FAIL midreset_abort: REQ_READY=%b sts_delta=%0d, required 0 0",
                     REQ_READY, sts_count - s0);
        end
        busy_force = 1'b0;
        @(negedge CLK);
        checks++;
        if (REQ_READY !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ready: REQ_READY=%b after BUSY fell, required 1", REQ_READY);
        end
        send_req(5'd8, 32'h8888_8888, 32'h0, 1'b1, 2'b00, 1'b0);
        wait_sts(s0 + 1, 200);
        checks++;
        if (WR_CNT !== 32'd1 || STS_ADDR !== 5'd8) begin
            errors++;
            $display("FAIL midreset_next: WR_CNT=%0d addr=%0d, required 1 8", WR_CNT, STS_ADDR);
        end
    endtask

    initial begin
        test_reset();
        test_verify_ok();
        test_shadowed();
        test_no_match();
        test_timeout();
        test_back_to_back();
        test_reset_mid_verify();
        repeat (5) @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcam_entry_loader.md
# tcam_entry_loader

Write-side controller for the TCAM. It accepts entry-update requests (address, data, mask) over a valid/ready handshake and drives the TCAM write port (WE, ADDR_WR, DIN, DATA_MASK), honouring BUSY. It can optionally read back each written entry through the TCAM compare port and report a per-request status. It sits between the control-register block and the `tcam` instance.

## Interface
Parameters:
- C_TCAM_ADDR_WIDTH, 5, TCAM address width.
- C_TCAM_DATA_WIDTH, 32, TCAM data and mask width.
- C_BUSY_GUARD, 2, minimum number of WAIT cycles before BUSY is sampled (covers the BUSY assertion delay).
- C_CMP_LAT, 2, compare-port latency in cycles, from CMP_DIN valid to MATCH/MATCH_ADDR valid.
- C_TIMEOUT, 1024, maximum number of WAIT cycles before a timeout is declared.

Ports:
- CLK  in  1  the single clock.
- RESETN  in  1  synchronous, active-low reset.
- REQ_VALID  in  1  request valid.
- REQ_READY  out  1  loader can accept a request.
- REQ_ADDR  in  C_TCAM_ADDR_WIDTH  target entry.
- REQ_DATA  in  C_TCAM_DATA_WIDTH  entry data.
- REQ_MASK  in  C_TCAM_DATA_WIDTH  entry mask.
- REQ_VERIFY  in  1  when 1, read the entry back after the write.
- WE  out  1  TCAM write strobe.
- ADDR_WR  out  C_TCAM_ADDR_WIDTH  TCAM write address.
- DIN  out  C_TCAM_DATA_WIDTH  TCAM write data.
- DATA_MASK  out  C_TCAM_DATA_WIDTH  TCAM write mask.
- BUSY  in  1  TCAM write in progress.
- CMP_SEL  out  1  loader owns the compare port; the external mux selects CMP_DIN/CMP_DATA_MASK from this block.
- CMP_DIN  out  C_TCAM_DATA_WIDTH  compare data.
- CMP_DATA_MASK  out  C_TCAM_DATA_WIDTH  compare mask.
- MATCH  in  1  TCAM match.
- MATCH_ADDR  in  C_TCAM_ADDR_WIDTH  TCAM match address.
- STS_VALID  out  1  one-cycle status pulse.
- STS_ERR  out  2  status code: 00 ok, 01 no match, 10 address mismatch, 11 timeout.
- STS_ADDR  out  C_TCAM_ADDR_WIDTH  address of the completed request.
- WR_CNT  out  32  count of issued WE pulses.

## Operation
- The FSM has five states: IDLE, WRITE, WAIT, VERIFY, REPORT.
- IDLE:
  - REQ_READY = !BUSY.
  - On REQ_VALID&&REQ_READY, register addr/data/mask/verify and go to WRITE.
- WRITE:
  - WE=1 for exactly one cycle with the registered ADDR_WR/DIN/DATA_MASK.
  - WR_CNT increments; it wraps at 2^32-1 → 0.
  - Go to WAIT.
- WAIT:
  - A cycle counter starts at 0.
  - For counter < C_BUSY_GUARD, BUSY is ignored.
  - After that, the first cycle with BUSY==0 goes to VERIFY if verify=1, otherwise to REPORT with STS_ERR=00.
  - If the counter reaches C_TIMEOUT-1 while BUSY==1, go to REPORT with STS_ERR=11. VERIFY is skipped.
- VERIFY:
  - CMP_SEL=1, CMP_DIN=data, CMP_DATA_MASK=mask, held for C_CMP_LAT+1 cycles.
  - MATCH and MATCH_ADDR are sampled in the last cycle.
  - MATCH==0 → STS_ERR=01.
  - MATCH==1 with MATCH_ADDR!=addr → STS_ERR=10 (entry shadowed by another entry).
  - Otherwise STS_ERR=00.
- REPORT:
  - STS_VALID=1 for one cycle; STS_ERR and STS_ADDR hold until the next REPORT.
  - Go to IDLE.
- Only one request is in flight at a time. REQ_READY=0 in every state except IDLE.
- DIN, DATA_MASK and ADDR_WR hold their registered values outside WRITE. Only WE qualifies them.

## Timing
- Reset (RESETN=0 at a rising edge):
  - State goes to IDLE.
  - WE, CMP_SEL, STS_VALID, STS_ERR, STS_ADDR, ADDR_WR, DIN, DATA_MASK, CMP_DIN, CMP_DATA_MASK and WR_CNT all reset to 0.
  - REQ_READY follows !BUSY in the first cycle after reset.
- Reset mid-operation aborts the request with no STS_VALID. If the TCAM is still BUSY, REQ_READY stays 0 until BUSY falls.
- Request accepted at edge t:
  - WE=1 in cycle t+1.
  - WAIT starts at t+2.
  - Earliest BUSY sample is at t+2+C_BUSY_GUARD.
- No-verify latency, accept edge to STS_VALID: 3+C_BUSY_GUARD+(extra BUSY cycles).
- Verify adds C_CMP_LAT+1 cycles.
- After STS_VALID in cycle r, REQ_READY can be 1 in cycle r+1, giving back-to-back requests.
- REQ_VALID asserted during a non-IDLE state is not accepted and must be held by the requester.
- BUSY falling in the same cycle the guard expires counts as done.
- BUSY falling in the same cycle the timeout expires counts as done, not timeout.

## Test plan
- Write addr=5, data=0xDEADBEEF, mask=0, verify=1; TCAM model BUSY for 16 cycles, then MATCH=1, MATCH_ADDR=5 → one WE pulse, STS_VALID with STS_ERR=00, STS_ADDR=5, WR_CNT=1.
- Entry 2 preloaded with the same data; write addr=9, verify=1; model returns MATCH_ADDR=2 → STS_ERR=10, STS_ADDR=9.
- Model never asserts MATCH on a verify write → STS_ERR=01. The same request with verify=0 → STS_ERR=00, and CMP_SEL never rises.
- BUSY held high indefinitely with C_TIMEOUT=1024 → STS_VALID exactly 1024 WAIT cycles after WAIT entry, STS_ERR=11, no CMP_SEL.
- Four back-to-back requests with REQ_VALID held high → exactly four WE pulses, none while BUSY=1, four STS_VALID pulses in order, WR_CNT=4.
- RESETN pulsed low during VERIFY → no STS_VALID, all outputs 0, and REQ_READY rises after BUSY=0; a following request completes normally.
